id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rstN  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port flush  input  1  kill held and incoming entry.
REQ-005 The block SHALL have port inValid  input  1  decode offers an entry.
REQ-006 The block SHALL have port inReady  output  1  stage accepts an entry this cycle.
REQ-007 The block SHALL have port inAluControl  input  4  ALU operation code.
REQ-008 The block SHALL have port inOp1Sel  input  2  op1 source: 0 rs1, 1 pc, 2 zero, 3 zero.
REQ-009 The block SHALL have port inOp2Sel  input  1  op2 source: 0 rs2, 1 imm.
REQ-010 The block SHALL have port inPc  input  XLEN  instruction address.
REQ-011 The block SHALL have port inImm  input  XLEN  sign-extended immediate.
REQ-012 The block SHALL have port inRs1Addr  input  5  source register 1 index.
REQ-013 The block SHALL have port inRs2Addr  input  5  source register 2 index.
REQ-014 The block SHALL have port inRs1Data  input  XLEN  register-file read value 1.
REQ-015 The block SHALL have port inRs2Data  input  XLEN  register-file read value 2.
REQ-016 The block SHALL have port inRdAddr  input  5  destination register index.
REQ-017 The block SHALL have port inRegWrite  input  1  entry writes rd.
REQ-018 The block SHALL have port fwdExMem  input  fwd_t  EX/MEM bypass {regWrite, rd, data}.
REQ-019 The block SHALL have port fwdMemWb  input  fwd_t  MEM/WB bypass {regWrite, rd, data}.
REQ-020 The block SHALL have port outValid  output  1  held entry valid toward ALU.
REQ-021 The block SHALL have port outReady  input  1  downstream consumes held entry.
REQ-022 The block SHALL have port aluControl  output  4  registered ALU operation code.
REQ-023 The block SHALL have port op1, op2  output  XLEN each  forwarded, selected ALU operands.
REQ-024 The block SHALL have ports rdAddr (5) and regWrite (1), both outputs, the registered destination fields.

Function
REQ-025 inReady SHALL equal (!outValid || outReady); load occurs when inValid && inReady && !flush.
REQ-026 On load, all in* fields SHALL be captured; outValid SHALL be 1 next cycle; latency 1 cycle.
REQ-027 If outValid && outReady and no load, outValid SHALL clear next cycle; if outValid && !outReady, all held fields SHALL hold.
REQ-028 flush SHALL clear outValid and regWrite next cycle and discard any same-cycle input (flush wins over load and hold).
REQ-029 Forwarded rsN value SHALL be: fwdExMem.data if fwdExMem.regWrite && rd==rsN && rsN!=0; else fwdMemWb.data under the same rule; else the held rsN data.
REQ-030 Forwarding SHALL be combinational from held state each cycle, so it remains correct during stalls.
REQ-031 While an entry is held, a matching fwdMemWb write (rsN!=0) SHALL update the held rsN data, so the value survives writeback retiring.
REQ-032 Register x0 SHALL never be forwarded; a held rsN==0 SHALL present held data unchanged.
REQ-033 op1 SHALL be the forwarded rs1 value, held pc, or 0 per held op1Sel; op2 SHALL be the forwarded rs2 value or held imm per held op2Sel.
REQ-034 When outValid==0, aluControl, op1, op2, rdAddr SHALL still show held values; regWrite SHALL be 0.

Reset
REQ-035 On rstN low, outValid, regWrite, aluControl (ADD=0), rdAddr and all held data/selects SHALL be 0 immediately; op1=op2=0.
REQ-036 Reset mid-stall SHALL drop the held entry; first load after release behaves as REQ-026.

Structure
REQ-037 Shared package rv32_pkg SHALL hold fwd_t, op1Sel/op2Sel enums and the 4-bit ALU op enum (ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRA 6, SRL 7, OR 8, AND 9, EQ a, NE b, GE c, GEU d).
REQ-038 One sub-module OperandForward (pure combinational priority bypass mux) SHALL be instantiated twice, for rs1 and rs2.

Verification
REQ-039 Load ADD rs1=x3(5), rs2=x4(7), outReady=1 -> next cycle outValid=1, op1=5, op2=7, aluControl=0.
REQ-040 Held rs1=x3, fwdExMem{1,3,0x10} and fwdMemWb{1,3,0x20} -> op1=0x10; x0 with fwdExMem{1,0,0xFF} -> op1 = held data.
REQ-041 Stall outReady=0 3 cycles, fwdMemWb{1,4,0x99} pulses cycle 1 -> op2=0x99 in all later stall cycles; inReady=0 throughout.
REQ-042 flush with inValid=1 while holding -> next cycle outValid=0, regWrite=0, input discarded.
REQ-043 Back-to-back entries with outReady=1 -> one entry per cycle, inReady stays 1; op1Sel=pc 0x100, op2Sel=imm 4 -> op1=0x100, op2=4.
REQ-044 rstN low during stall -> outValid=0, all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types: bypass bundle, operand selects and ALU opcodes.
// Also holds the bypass match rule used by every forwarding mux.
package rv32_pkg;

  localparam int FWD_W = 32;

  typedef struct packed {
    logic             regWrite;
    logic [4:0]       rd;
    logic [FWD_W-1:0] data;
  } fwd_t;

  typedef enum logic [1:0] {
    OP1_RS1      = 2'd0,
    OP1_PC       = 2'd1,
    OP1_ZERO     = 2'd2,
    OP1_ZERO_ALT = 2'd3
  } op1_sel_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRA  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_EQ   = 4'ha,
    ALU_NE   = 4'hb,
    ALU_GE   = 4'hc,
    ALU_GEU  = 4'hd
  } alu_op_e;

  // x0 is hardwired to zero, so a write aimed at it must never be bypassed.
  function automatic logic fwd_hit(input fwd_t f, input logic [4:0] rs);
    return f.regWrite && (f.rd == rs) && (rs != 5'd0);
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Priority bypass mux for one source operand: EX/MEM beats MEM/WB beats the
// held register-file value.
module OperandForward
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  fwd_t            ex_mem,
  input  fwd_t            mem_wb,
  output logic [XLEN-1:0] value,
  output logic            mem_wb_hit
);

  logic ex_mem_hit;

  assign ex_mem_hit = fwd_hit(ex_mem, rs_addr);
  assign mem_wb_hit = fwd_hit(mem_wb, rs_addr);

  always_comb begin
    value = rs_data;
    if (ex_mem_hit) begin
      value = XLEN'(ex_mem.data);
    end else if (mem_wb_hit) begin
      value = XLEN'(mem_wb.data);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, and operand
// forwarding computed from the held entry so it stays correct across stalls.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [3:0]      inAluControl,
  input  logic [1:0]      inOp1Sel,
  input  logic            inOp2Sel,
  input  logic [XLEN-1:0] inPc,
  input  logic [XLEN-1:0] inImm,
  input  logic [4:0]      inRs1Addr,
  input  logic [4:0]      inRs2Addr,
  input  logic [XLEN-1:0] inRs1Data,
  input  logic [XLEN-1:0] inRs2Data,
  input  logic [4:0]      inRdAddr,
  input  logic            inRegWrite,
  input  fwd_t            fwdExMem,
  input  fwd_t            fwdMemWb,
  output logic            outValid,
  input  logic            outReady,
  output logic [3:0]      aluControl,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [4:0]      rdAddr,
  output logic            regWrite
);

  logic            valid_q;
  logic [3:0]      alu_q;
  logic [1:0]      op1_sel_q;
  logic            op2_sel_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_addr_q;
  logic [4:0]      rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [4:0]      rd_q;
  logic            reg_write_q;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            rs1_wb_hit;
  logic            rs2_wb_hit;
  logic            load;

  assign inReady = !valid_q || outReady;
  assign load    = inValid && inReady && !flush;

  // Flush beats load and hold. While an entry sits here, a MEM/WB write to one
  // of its sources is absorbed so the value outlives the writeback stage.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q     <= 1'b0;
      alu_q       <= ALU_ADD;
      op1_sel_q   <= OP1_RS1;
      op2_sel_q   <= OP2_RS2;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (load) begin
      valid_q     <= 1'b1;
      alu_q       <= inAluControl;
      op1_sel_q   <= inOp1Sel;
      op2_sel_q   <= inOp2Sel;
      pc_q        <= inPc;
      imm_q       <= inImm;
      rs1_addr_q  <= inRs1Addr;
      rs2_addr_q  <= inRs2Addr;
      rs1_data_q  <= inRs1Data;
      rs2_data_q  <= inRs2Data;
      rd_q        <= inRdAddr;
      reg_write_q <= inRegWrite;
    end else begin
      if (valid_q && outReady) begin
        valid_q <= 1'b0;
      end
      if (valid_q && rs1_wb_hit) begin
        rs1_data_q <= XLEN'(fwdMemWb.data);
      end
      if (valid_q && rs2_wb_hit) begin
        rs2_data_q <= XLEN'(fwdMemWb.data);
      end
    end
  end

  OperandForward #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr    (rs1_addr_q),
    .rs_data    (rs1_data_q),
    .ex_mem     (fwdExMem),
    .mem_wb     (fwdMemWb),
    .value      (rs1_fwd),
    .mem_wb_hit (rs1_wb_hit)
  );

  OperandForward #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr    (rs2_addr_q),
    .rs_data    (rs2_data_q),
    .ex_mem     (fwdExMem),
    .mem_wb     (fwdMemWb),
    .value      (rs2_fwd),
    .mem_wb_hit (rs2_wb_hit)
  );

  always_comb begin
    op1 = '0;
    case (op1_sel_q)
      OP1_RS1: op1 = rs1_fwd;
      OP1_PC:  op1 = pc_q;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    op2 = rs2_fwd;
    if (op2_sel_q == OP2_IMM) begin
      op2 = imm_q;
    end
  end

  assign outValid   = valid_q;
  assign aluControl = alu_q;
  assign rdAddr     = rd_q;
  assign regWrite   = valid_q && reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, flush, forwarding priority,
// stall-time writeback capture and asynchronous reset.
module tb_id_ex_stage;
  import rv32_pkg::*;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [3:0]  inAluControl;
  logic [1:0]  inOp1Sel;
  logic        inOp2Sel;
  logic [31:0] inPc;
  logic [31:0] inImm;
  logic [4:0]  inRs1Addr;
  logic [4:0]  inRs2Addr;
  logic [31:0] inRs1Data;
  logic [31:0] inRs2Data;
  logic [4:0]  inRdAddr;
  logic        inRegWrite;
  fwd_t        fwdExMem;
  fwd_t        fwdMemWb;
  logic        outValid;
  logic        outReady;
  logic [3:0]  aluControl;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  rdAddr;
  logic        regWrite;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .flush        (flush),
    .inValid      (inValid),
    .inReady      (inReady),
    .inAluControl (inAluControl),
    .inOp1Sel     (inOp1Sel),
    .inOp2Sel     (inOp2Sel),
    .inPc         (inPc),
    .inImm        (inImm),
    .inRs1Addr    (inRs1Addr),
    .inRs2Addr    (inRs2Addr),
    .inRs1Data    (inRs1Data),
    .inRs2Data    (inRs2Data),
    .inRdAddr     (inRdAddr),
    .inRegWrite   (inRegWrite),
    .fwdExMem     (fwdExMem),
    .fwdMemWb     (fwdMemWb),
    .outValid     (outValid),
    .outReady     (outReady),
    .aluControl   (aluControl),
    .op1          (op1),
    .op2          (op2),
    .rdAddr       (rdAddr),
    .regWrite     (regWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_entry(input logic [3:0] alu, input logic [1:0] s1, input logic s2,
                             input logic [31:0] pc, input logic [31:0] imm,
                             input logic [4:0] r1, input logic [31:0] d1,
                             input logic [4:0] r2, input logic [31:0] d2,
                             input logic [4:0] rd, input logic rw);
    inValid      = 1'b1;
    inAluControl = alu;
    inOp1Sel     = s1;
    inOp2Sel     = s2;
    inPc         = pc;
    inImm        = imm;
    inRs1Addr    = r1;
    inRs1Data    = d1;
    inRs2Addr    = r2;
    inRs2Data    = d2;
    inRdAddr     = rd;
    inRegWrite   = rw;
  endtask

  task automatic clear_fwd();
    fwdExMem = '0;
    fwdMemWb = '0;
  endtask

  initial begin
    rstN     = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;
    inValid  = 1'b0;
    apply_entry(4'h0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0);
    inValid  = 1'b0;
    clear_fwd();
    #1;
    check_output("rst_outValid",   32'(outValid),   32'h0);
    check_output("rst_regWrite",   32'(regWrite),   32'h0);
    check_output("rst_aluControl", 32'(aluControl), 32'h0);
    check_output("rst_rdAddr",     32'(rdAddr),     32'h0);
    check_output("rst_op1",        op1,             32'h0);
    check_output("rst_op2",        op2,             32'h0);
    check_output("rst_inReady",    32'(inReady),    32'h1);
    step();
    step();
    rstN = 1'b1;

    $display("[TB] basic load latency");
    apply_entry(ALU_ADD, OP1_RS1, OP2_RS2, 32'h0, 32'h0, 5'd3, 32'd5, 5'd4, 32'd7, 5'd5, 1'b1);
    outReady = 1'b1;
    step();
    inValid = 1'b0;
    check_output("load_outValid",   32'(outValid),   32'h1);
    check_output("load_op1",        op1,             32'd5);
    check_output("load_op2",        op2,             32'd7);
    check_output("load_aluControl", 32'(aluControl), 32'h0);
    check_output("load_rdAddr",     32'(rdAddr),     32'd5);
    check_output("load_regWrite",   32'(regWrite),   32'h1);

    $display("[TB] forwarding priority");
    outReady = 1'b0;
    fwdExMem = '{regWrite: 1'b1, rd: 5'd3, data: 32'h10};
    fwdMemWb = '{regWrite: 1'b1, rd: 5'd3, data: 32'h20};
    #1;
    check_output("fwd_exmem_wins", op1, 32'h10);
    fwdExMem = '0;
    #1;
    check_output("fwd_memwb_only", op1, 32'h20);
    fwdExMem = '{regWrite: 1'b0, rd: 5'd3, data: 32'h30};
    fwdMemWb = '0;
    #1;
    check_output("fwd_exmem_nowrite", op1, 32'd5);
    clear_fwd();

    $display("[TB] stall with writeback pulse");
    apply_entry(ALU_SUB, OP1_RS1, OP2_RS2, 32'h0, 32'h0, 5'd1, 32'h77, 5'd2, 32'h88, 5'd6, 1'b1);
    fwdMemWb = '{regWrite: 1'b1, rd: 5'd4, data: 32'h99};
    #1;
    check_output("stall1_inReady", 32'(inReady), 32'h0);
    check_output("stall1_op2",     op2,           32'h99);
    step();
    clear_fwd();
    check_output("stall2_inReady",  32'(inReady),  32'h0);
    check_output("stall2_op2",      op2,           32'h99);
    check_output("stall2_outValid", 32'(outValid), 32'h1);
    step();
    check_output("stall3_inReady", 32'(inReady), 32'h0);
    check_output("stall3_op2",     op2,           32'h99);
    check_output("stall3_op1",     op1,           32'd5);

    $display("[TB] flush over pending input");
    flush = 1'b1;
    step();
    flush   = 1'b0;
    inValid = 1'b0;
    check_output("flush_outValid",   32'(outValid),   32'h0);
    check_output("flush_regWrite",   32'(regWrite),   32'h0);
    check_output("flush_inReady",    32'(inReady),    32'h1);
    check_output("flush_aluControl", 32'(aluControl), 32'h0);
    check_output("flush_op1",        op1,             32'd5);
    check_output("flush_rdAddr",     32'(rdAddr),     32'd5);

    $display("[TB] x0 never forwarded");
    apply_entry(ALU_XOR, OP1_RS1, OP2_IMM, 32'h0, 32'h1234, 5'd0, 32'h55, 5'd0, 32'h66, 5'd0, 1'b0);
    step();
    inValid  = 1'b0;
    fwdExMem = '{regWrite: 1'b1, rd: 5'd0, data: 32'hFF};
    fwdMemWb = '{regWrite: 1'b1, rd: 5'd0, data: 32'hEE};
    #1;
    check_output("x0_op1",        op1,             32'h55);
    check_output("x0_op2_imm",    op2,             32'h1234);
    check_output("x0_aluControl", 32'(aluControl), 32'h5);
    check_output("x0_regWrite",   32'(regWrite),   32'h0);
    step();
    check_output("x0_op1_held", op1, 32'h55);
    clear_fwd();

    $display("[TB] back-to-back entries");
    apply_entry(ALU_ADD, OP1_PC, OP2_IMM, 32'h100, 32'h4, 5'd1, 32'h1, 5'd2, 32'h2, 5'd7, 1'b1);
    outReady = 1'b1;
    #1;
    check_output("b2b_inReady_pre", 32'(inReady), 32'h1);
    step();
    check_output("b2b_a_op1",     op1,           32'h100);
    check_output("b2b_a_op2",     op2,           32'h4);
    check_output("b2b_a_rdAddr",  32'(rdAddr),   32'd7);
    check_output("b2b_a_inReady", 32'(inReady),  32'h1);
    apply_entry(ALU_AND, OP1_ZERO, OP2_RS2, 32'h200, 32'h8, 5'd1, 32'hAA, 5'd9, 32'h33, 5'd8, 1'b1);
    step();
    check_output("b2b_b_op1",        op1,             32'h0);
    check_output("b2b_b_op2",        op2,             32'h33);
    check_output("b2b_b_aluControl", 32'(aluControl), 32'h9);
    check_output("b2b_b_outValid",   32'(outValid),   32'h1);
    fwdMemWb = '{regWrite: 1'b1, rd: 5'd9, data: 32'h44};
    #1;
    check_output("b2b_b_op2_memwb", op2, 32'h44);
    fwdExMem = '{regWrite: 1'b1, rd: 5'd9, data: 32'h66};
    #1;
    check_output("b2b_b_op2_exmem", op2, 32'h66);
    clear_fwd();
    apply_entry(ALU_SUB, OP1_ZERO_ALT, OP2_IMM, 32'h300, 32'hFFFF_FFFC, 5'd1, 32'hBB, 5'd2, 32'hCC, 5'd9, 1'b1);
    step();
    check_output("b2b_c_op1",        op1,             32'h0);
    check_output("b2b_c_op2",        op2,             32'hFFFF_FFFC);
    check_output("b2b_c_aluControl", 32'(aluControl), 32'h1);
    check_output("b2b_c_inReady",    32'(inReady),    32'h1);
    inValid = 1'b0;
    step();
    check_output("drain_outValid",   32'(outValid),   32'h0);
    check_output("drain_regWrite",   32'(regWrite),   32'h0);
    check_output("drain_aluControl", 32'(aluControl), 32'h1);
    check_output("drain_rdAddr",     32'(rdAddr),     32'd9);

    $display("[TB] async reset during stall");
    apply_entry(ALU_SRA, OP1_RS1, OP2_RS2, 32'h0, 32'h0, 5'd2, 32'h5A, 5'd6, 32'h3C, 5'd10, 1'b1);
    outReady = 1'b0;
    step();
    inValid = 1'b0;
    check_output("pre_rst_op1", op1, 32'h5A);
    step();
    check_output("pre_rst_inReady", 32'(inReady), 32'h0);
    #2;
    rstN = 1'b0;
    #1;
    check_output("arst_outValid",   32'(outValid),   32'h0);
    check_output("arst_regWrite",   32'(regWrite),   32'h0);
    check_output("arst_aluControl", 32'(aluControl), 32'h0);
    check_output("arst_rdAddr",     32'(rdAddr),     32'h0);
    check_output("arst_op1",        op1,             32'h0);
    check_output("arst_op2",        op2,             32'h0);
    @(negedge clk);
    rstN = 1'b1;
    apply_entry(ALU_SLT, OP1_RS1, OP2_RS2, 32'h0, 32'h0, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 1'b1);
    outReady = 1'b1;
    step();
    inValid = 1'b0;
    check_output("post_rst_outValid",   32'(outValid),   32'h1);
    check_output("post_rst_op1",        op1,             32'h11);
    check_output("post_rst_op2",        op2,             32'h22);
    check_output("post_rst_aluControl", 32'(aluControl), 32'h3);
    step();
    check_output("post_rst_drain", 32'(outValid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
